// File: rtl/lsu.sv
// Load/store unit: sequences one load or store through dbusif (IDLE/ADDR/DATA).
// Define LSU_MISALIGN_CHECK_EN to reject misaligned half/word accesses via a MIS state.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        ready,
  input  logic        w_rb,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        acc_fault,
  output logic        misalign,
  output logic        acc_req,
  output logic        acc_w_rb,
  output logic [1:0]  acc_size,
  output logic [31:0] acc_addr,
  output logic [31:0] acc_wdata,
  input  logic        data_vld,
  input  logic [31:0] data,
  input  logic        data_has_fault,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
`ifdef LSU_MISALIGN_CHECK_EN
  localparam logic [1:0] MIS  = 2'd3;
`endif

  logic [1:0]  r_state;
  logic        r_w_rb;
  logic [1:0]  r_size;
  logic        r_sext;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic [1:0]  w_size;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_addr;
  logic        w_mis;
  logic        w_accept;
  logic        w_data_done;
  logic        w_mis_done;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign w_size   = (size == 2'd3) ? 2'd2 : size;
  assign w_accept = req & (r_state == IDLE);

  always_comb begin
    w_wdata_rep = wdata;
    case (w_size)
      2'd0:    w_wdata_rep = {4{wdata[7:0]}};
      2'd1:    w_wdata_rep = {2{wdata[15:0]}};
      default: w_wdata_rep = wdata;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_addr = addr;
  assign w_mis  = ((w_size == 2'd1) & addr[0]) | ((w_size == 2'd2) & (addr[1:0] != 2'd0));
`else
  // Without the check, misaligned addresses are silently rounded down to natural alignment.
  always_comb begin
    w_addr = addr;
    case (w_size)
      2'd1:    w_addr = {addr[31:1], 1'b0};
      2'd2:    w_addr = {addr[31:2], 2'b00};
      default: w_addr = addr;
    endcase
  end
  assign w_mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_w_rb  <= 1'b0;
      r_size  <= 2'd0;
      r_sext  <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_w_rb  <= w_rb;
            r_size  <= w_size;
            r_sext  <= sext;
            r_addr  <= w_addr;
            r_wdata <= w_wdata_rep;
`ifdef LSU_MISALIGN_CHECK_EN
            r_state <= w_mis ? MIS : ADDR;
`else
            r_state <= ADDR;
`endif
          end
        end
        ADDR: r_state <= DATA;
        DATA: if (data_vld) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_byte = data[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = data[7:0];
      2'd1: w_byte = data[15:8];
      2'd2: w_byte = data[23:16];
      2'd3: w_byte = data[31:24];
      default: w_byte = data[7:0];
    endcase
  end

  assign w_half = r_addr[1] ? data[31:16] : data[15:0];

  always_comb begin
    w_ext = data;
    case (r_size)
      2'd0:    w_ext = {{24{r_sext & w_byte[7]}}, w_byte};
      2'd1:    w_ext = {{16{r_sext & w_half[15]}}, w_half};
      default: w_ext = data;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_mis_done = (r_state == MIS);
`else
  assign w_mis_done = 1'b0;
`endif

  assign w_data_done = (r_state == DATA) & data_vld;
  assign done        = w_data_done | w_mis_done;
  assign acc_fault   = w_data_done & data_has_fault;
  assign misalign    = w_mis_done;
  assign rdata       = (w_data_done & ~r_w_rb & ~data_has_fault) ? w_ext : 32'd0;
  assign ready       = (r_state == IDLE);
  assign acc_req     = (r_state == ADDR);
  assign acc_w_rb    = r_w_rb;
  assign acc_size    = r_size;
  assign acc_addr    = r_addr;
  assign acc_wdata   = r_wdata;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios plus randomized ops against a behavioural model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, w_rb, sext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        done, ready, acc_fault, misalign;
  logic [31:0] rdata;
  logic        acc_req, acc_w_rb;
  logic [1:0]  acc_size;
  logic [31:0] acc_addr, acc_wdata;
  logic        data_vld, data_has_fault;
  logic [31:0] data;
  logic [1:0]  dbg_state;

  int n_pass = 0;
  int n_total = 0;
  int cyc_cnt = 0;
  logic [31:0] exp_q[$];

  // run_op observations
  int          o_done_cyc, o_req_cnt;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [1:0]  o_size;
  logic        o_wrb, o_stable, o_fault, o_mis, o_ready_after;

  lsu dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .w_rb(w_rb), .size(size),
    .sext(sext), .addr(addr), .wdata(wdata), .done(done), .rdata(rdata),
    .acc_fault(acc_fault), .misalign(misalign), .acc_req(acc_req),
    .acc_w_rb(acc_w_rb), .acc_size(acc_size), .acc_addr(acc_addr),
    .acc_wdata(acc_wdata), .data_vld(data_vld), .data(data),
    .data_has_fault(data_has_fault), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 0) return (wd % 256) * 32'h0101_0101;
    if (sz == 1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_addr(input logic [1:0] sz, input logic [31:0] a);
    if (CHK || sz == 0) return a;
    if (sz == 1) return a - (a % 2);
    return a - (a % 4);
  endfunction

  function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
    if (!CHK) return 1'b0;
    if (sz == 1) return (a % 2) != 0;
    if (sz >= 2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_rdata(input logic wr, input logic [1:0] sz, input logic sx,
                                          input logic [31:0] a, input logic [31:0] d,
                                          input logic flt);
    logic [31:0] v;
    if (wr || flt) return 32'd0;
    if (sz == 0) begin
      v = (d >> (8 * (a % 4))) % 256;
      if (sx && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (sz == 1) begin
      v = (d >> (16 * ((a / 2) % 2))) % 65536;
      if (sx && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return d;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; returns shortly after the negedge of the cycle following done.
  task automatic run_op(input logic wr, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] bus_d, input logic flt, input int waits);
    int a_cyc = -1;
    bit got = 0;
    o_req_cnt = 0; o_stable = 1; o_done_cyc = -1;
    o_rdata = 'x; o_fault = 'x; o_mis = 'x;
    o_addr = 'x; o_size = 'x; o_wrb = 'x; o_wdata = 'x;
    for (int c = 0; c < 40 && !got; c++) begin
      if (c > 0) @(negedge clk);
      req = (c == 0); w_rb = wr; size = sz; sext = sx; addr = a; wdata = wd;
      data_vld = (a_cyc >= 0 && c == a_cyc + 1 + waits);
      data = data_vld ? bus_d : $urandom; data_has_fault = data_vld ? flt : $urandom_range(0, 1);
      #1;
      if (acc_req) begin
        o_req_cnt++; a_cyc = c; o_addr = acc_addr; o_size = acc_size; o_wrb = acc_w_rb;
      end
      if (a_cyc >= 0 && c == a_cyc + 1) o_wdata = acc_wdata;
      else if (a_cyc >= 0 && c > a_cyc + 1 && acc_wdata !== o_wdata) o_stable = 0;
      if (done) begin
        got = 1; o_done_cyc = c; o_rdata = rdata; o_fault = acc_fault; o_mis = misalign;
      end
    end
    n_total++;
    if (!got) $display("FAIL op_timeout got=no_done exp=done_within_40");
    else n_pass++;
    @(negedge clk);
    req = 0; data_vld = 0; data_has_fault = 0;
    #1 o_ready_after = ready;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; req = 0; w_rb = 0; size = 0; sext = 0; addr = 0; wdata = 0;
    data_vld = 0; data = 0; data_has_fault = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0; #1;
    n_total++; if (ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", ready); else n_pass++;
    n_total++; if (acc_req !== 1'b0) $display("FAIL rst_acc_req got=%b exp=0", acc_req); else n_pass++;
    n_total++; if ({done, acc_fault, misalign} !== 3'b000)
      $display("FAIL rst_flags got=%b exp=000", {done, acc_fault, misalign}); else n_pass++;
    n_total++; if ({acc_addr, acc_wdata, rdata} !== 96'd0)
      $display("FAIL rst_buses got=%h exp=0", {acc_addr, acc_wdata, rdata}); else n_pass++;
    n_total++; if ({acc_w_rb, acc_size} !== 3'd0)
      $display("FAIL rst_ctl got=%b exp=000", {acc_w_rb, acc_size}); else n_pass++;
  endtask

  task automatic test_load_byte();
    run_op(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80FF_1234, 1'b0, 0);
    n_total++; if (o_addr !== 32'h1003) $display("FAIL lb_addr got=%h exp=00001003", o_addr); else n_pass++;
    n_total++; if (o_size !== 2'd0) $display("FAIL lb_size got=%0d exp=0", o_size); else n_pass++;
    n_total++; if (o_done_cyc !== 2) $display("FAIL lb_done_cyc got=%0d exp=2", o_done_cyc); else n_pass++;
    n_total++; if (o_rdata !== 32'hFFFF_FF80) $display("FAIL lb_rdata got=%h exp=ffffff80", o_rdata); else n_pass++;
    n_total++; if (o_ready_after !== 1'b1) $display("FAIL lb_ready got=%b exp=1", o_ready_after); else n_pass++;
  endtask

  task automatic test_store_half();
    run_op(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_ABCD, 32'h1234_5678, 1'b0, 3);
    n_total++; if (o_wdata !== 32'hABCD_ABCD) $display("FAIL sh_wdata got=%h exp=abcdabcd", o_wdata); else n_pass++;
    n_total++; if (o_stable !== 1'b1) $display("FAIL sh_wdata_stable got=%b exp=1", o_stable); else n_pass++;
    n_total++; if (o_done_cyc !== 5) $display("FAIL sh_done_cyc got=%0d exp=5", o_done_cyc); else n_pass++;
    n_total++; if (o_wrb !== 1'b1) $display("FAIL sh_wrb got=%b exp=1", o_wrb); else n_pass++;
    n_total++; if (o_rdata !== 32'd0) $display("FAIL sh_rdata got=%h exp=0", o_rdata); else n_pass++;
  endtask

  task automatic test_fault();
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b1, 1);
    n_total++; if (o_fault !== 1'b1) $display("FAIL flt_fault got=%b exp=1", o_fault); else n_pass++;
    n_total++; if (o_rdata !== 32'd0) $display("FAIL flt_rdata got=%h exp=0", o_rdata); else n_pass++;
    n_total++; if (o_ready_after !== 1'b1) $display("FAIL flt_ready got=%b exp=1", o_ready_after); else n_pass++;
  endtask

  task automatic test_misalign();
    run_op(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
    if (CHK) begin
      n_total++; if (o_done_cyc !== 1) $display("FAIL mis_done_cyc got=%0d exp=1", o_done_cyc); else n_pass++;
      n_total++; if (o_mis !== 1'b1) $display("FAIL mis_flag got=%b exp=1", o_mis); else n_pass++;
      n_total++; if (o_req_cnt !== 0) $display("FAIL mis_acc_req got=%0d exp=0", o_req_cnt); else n_pass++;
    end else begin
      n_total++; if (o_addr !== 32'h3000) $display("FAIL mis_addr got=%h exp=00003000", o_addr); else n_pass++;
      n_total++; if (o_done_cyc !== 2) $display("FAIL mis_done_cyc got=%0d exp=2", o_done_cyc); else n_pass++;
      n_total++; if (o_mis !== 1'b0) $display("FAIL mis_flag got=%b exp=0", o_mis); else n_pass++;
      n_total++; if (o_rdata !== 32'hCAFE_F00D) $display("FAIL mis_rdata got=%h exp=cafef00d", o_rdata); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    req = 1; w_rb = 0; size = 2; sext = 0; addr = 32'h4000; wdata = 0;
    @(negedge clk); req = 0;            // ADDR
    @(negedge clk); rst = 1;            // DATA, reset asserted
    @(negedge clk); rst = 0;
    data_vld = 1; data = 32'h5555_AAAA; data_has_fault = 0; #1;
    n_total++; if (done !== 1'b0) $display("FAIL rmid_done got=%b exp=0", done); else n_pass++;
    n_total++; if (ready !== 1'b1) $display("FAIL rmid_ready got=%b exp=1", ready); else n_pass++;
    n_total++; if (acc_req !== 1'b0) $display("FAIL rmid_acc_req got=%b exp=0", acc_req); else n_pass++;
    @(negedge clk); data_vld = 0;
    run_op(1'b0, 2'd1, 1'b1, 32'h4002, 32'h0, 32'h9ABC_0000, 1'b0, 0);
    n_total++; if (o_rdata !== 32'hFFFF_9ABC) $display("FAIL rmid_next_rdata got=%h exp=ffff9abc", o_rdata); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t0;
    t0 = cyc_cnt;
    run_op(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h0000_00A5, 1'b0, 0);
    run_op(1'b1, 2'd2, 1'b0, 32'h14, 32'h1111_2222, 32'h0, 1'b0, 0);
    n_total++; if (o_done_cyc !== 2) $display("FAIL b2b_done_cyc got=%0d exp=2", o_done_cyc); else n_pass++;
    run_op(1'b0, 2'd1, 1'b0, 32'h18, 32'h0, 32'h0000_7777, 1'b0, 0);
    n_total++; if (cyc_cnt - t0 !== 9) $display("FAIL b2b_span got=%0d exp=9", cyc_cnt - t0); else n_pass++;
  endtask

  task automatic test_random();
    logic wr, sx, flt;
    logic [1:0] sz, esz;
    logic [31:0] a, wd, d, e;
    int w;
    for (int i = 0; i < 40; i++) begin
      wr = $urandom_range(0, 1); sz = $urandom_range(0, 3); sx = $urandom_range(0, 1);
      a = $urandom; wd = $urandom; d = $urandom; flt = ($urandom_range(0, 7) == 0);
      w = $urandom_range(0, 3);
      esz = (sz == 3) ? 2'd2 : sz;
      run_op(wr, sz, sx, a, wd, d, flt, w);
      if (m_mis(esz, a)) begin
        exp_q.push_back(32'd1);
        e = exp_q.pop_front();
        n_total++; if ({31'd0, o_mis} !== e || o_done_cyc !== 1)
          $display("FAIL rnd_mis[%0d] got=%b/%0d exp=1/1", i, o_mis, o_done_cyc); else n_pass++;
      end else begin
        exp_q.push_back(m_rdata(wr, esz, sx, a, d, flt));
        e = exp_q.pop_front();
        n_total++; if (o_rdata !== e) $display("FAIL rnd_rdata[%0d] got=%h exp=%h", i, o_rdata, e); else n_pass++;
        n_total++; if (o_addr !== m_addr(esz, a) || o_size !== esz)
          $display("FAIL rnd_addr[%0d] got=%h/%0d exp=%h/%0d", i, o_addr, o_size, m_addr(esz, a), esz); else n_pass++;
        n_total++; if (o_wdata !== m_wdata(esz, wd) || o_stable !== 1'b1)
          $display("FAIL rnd_wdata[%0d] got=%h/%b exp=%h/1", i, o_wdata, o_stable, m_wdata(esz, wd)); else n_pass++;
        n_total++; if (o_done_cyc !== 2 + w || o_fault !== flt || o_req_cnt !== 1)
          $display("FAIL rnd_timing[%0d] got=%0d/%b/%0d exp=%0d/%b/1", i, o_done_cyc, o_fault, o_req_cnt, 2 + w, flt); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_fault();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
